// File: rtl/game_pkg.sv
// game_pkg
// Shared definitions for the game flow controller and the background drawer:
// game state encoding, background-state codes and the widths of the
// lives / level / timer / pause fields.
package game_pkg;

  localparam int BG_W    = 2;
  localparam int LIVES_W = 2;
  localparam int LEVEL_W = 3;
  localparam int TIME_W  = 7;
  localparam int PAUSE_W = 8;

  typedef enum logic [2:0] {
    ST_WELCOME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_PAUSE   = 3'd2,
    ST_OVER    = 3'd3,
    ST_WIN     = 3'd4
  } game_state_t;

  localparam logic [BG_W-1:0] BG_WELCOME = 2'b00;
  localparam logic [BG_W-1:0] BG_PLAY    = 2'b01;  // play and pause share a background
  localparam logic [BG_W-1:0] BG_OVER    = 2'b10;
  localparam logic [BG_W-1:0] BG_WIN     = 2'b11;

  // Background code shown for a given game state.
  function automatic logic [BG_W-1:0] bg_of_state(input game_state_t st);
    logic [BG_W-1:0] bg;
    case (st)
      ST_WELCOME: bg = BG_WELCOME;
      ST_PLAY:    bg = BG_PLAY;
      ST_PAUSE:   bg = BG_PLAY;
      ST_OVER:    bg = BG_OVER;
      ST_WIN:     bg = BG_WIN;
      default:    bg = BG_WELCOME;
    endcase
    return bg;
  endfunction

endpackage

// File: rtl/frame_sec_timer.sv
// frame_sec_timer
// Divides startOfFrame pulses down to one secTick per FRAMES_PER_SEC frames.
// Ports:
//   clk, reset    : system clock, asynchronous active-high reset
//   startOfFrame  : one-cycle pulse per video frame
//   clear         : holds the frame count at 0 (used whenever not playing)
//   secTick       : one-cycle pulse on the frame that wraps the count
module frame_sec_timer #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic clear,
  output logic secTick
);

  localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAMES_PER_SEC - 1);

  logic [CNT_W-1:0] frame_cnt_r;

  // secTick is decoded from the registered count so the controller sees it
  // in the same cycle as the wrapping frame pulse.
  assign secTick = startOfFrame & ~clear & (frame_cnt_r == CNT_MAX);

  // Frame counter: counts 0..FRAMES_PER_SEC-1, wraps, cleared on demand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      frame_cnt_r <= {CNT_W{1'b0}};
    end else if (startOfFrame) begin
      if (frame_cnt_r == CNT_MAX) begin
        frame_cnt_r <= {CNT_W{1'b0}};
      end else begin
        frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level game sequencing: welcome screen, play with a per-level countdown,
// pauses between lives/levels, game over and win screens.
// Ports:
//   clk, reset       : system clock, asynchronous active-high reset
//   startOfFrame     : one-cycle pulse per video frame
//   startKey         : level-sensitive start button (edge-detected inside)
//   playerHit        : pulse, player collided with a ball
//   allBallsCleared  : pulse, no balls left
//   bgState          : background selector (00 welcome, 01 play/pause, 10 over, 11 win)
//   freezeGame       : game objects must not move
//   levelLoad        : one-cycle pulse to respawn balls and player
//   lives, level, timeLeft : scoreboard values
module game_flow_controller
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int LEVEL_TIME     = 60,
  parameter int START_LIVES    = 3,
  parameter int MAX_LEVEL      = 4,
  parameter int PAUSE_FRAMES   = 90
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               startKey,
  input  logic               playerHit,
  input  logic               allBallsCleared,
  output logic [BG_W-1:0]    bgState,
  output logic               freezeGame,
  output logic               levelLoad,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  timeLeft
);

  localparam logic [TIME_W-1:0]  LEVEL_TIME_C  = TIME_W'(LEVEL_TIME);
  localparam logic [LIVES_W-1:0] START_LIVES_C = LIVES_W'(START_LIVES);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL_C   = LEVEL_W'(MAX_LEVEL);
  localparam logic [PAUSE_W-1:0] PAUSE_C       = PAUSE_W'(PAUSE_FRAMES);

  game_state_t        state_r, state_s;
  logic               key_prev_r;
  logic               key_edge_s;
  logic [PAUSE_W-1:0] pause_cnt_r, pause_cnt_s;
  logic [LIVES_W-1:0] lives_s;
  logic [LEVEL_W-1:0] level_s;
  logic [TIME_W-1:0]  time_s;
  logic               load_s;
  logic               sec_tick_s;
  logic               frame_clear_s;

  assign key_edge_s    = startKey & ~key_prev_r;
  // The frame divider only runs in PLAY, so every return to PLAY starts a fresh second.
  assign frame_clear_s = (state_r != ST_PLAY);

  frame_sec_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_frame_sec_timer (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .clear       (frame_clear_s),
    .secTick     (sec_tick_s)
  );

  // Next-state and next-output decode for the game FSM.
  always_comb begin
    state_s     = state_r;
    pause_cnt_s = pause_cnt_r;
    lives_s     = lives;
    level_s     = level;
    time_s      = timeLeft;
    load_s      = 1'b0;
    case (state_r)
      ST_WELCOME: begin
        if (key_edge_s) begin
          state_s = ST_PLAY;
          lives_s = START_LIVES_C;
          level_s = 3'd1;
          time_s  = LEVEL_TIME_C;
          load_s  = 1'b1;
        end else begin
          state_s = ST_WELCOME;
        end
      end
      ST_PLAY: begin
        // A hit outranks a simultaneous clear; running out of time counts as a hit.
        if (playerHit || (timeLeft == 7'd0)) begin
          if (lives <= 2'd1) begin
            state_s = ST_OVER;
            lives_s = 2'd0;
          end else begin
            state_s     = ST_PAUSE;
            lives_s     = lives - 2'd1;
            pause_cnt_s = PAUSE_C;
          end
        end else if (allBallsCleared) begin
          if (level == MAX_LEVEL_C) begin
            state_s = ST_WIN;
          end else begin
            state_s     = ST_PAUSE;
            level_s     = level + 3'd1;
            pause_cnt_s = PAUSE_C;
          end
        end else if (sec_tick_s && (timeLeft != 7'd0)) begin
          time_s = timeLeft - 7'd1;
        end else begin
          state_s = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_cnt_r == 8'd0) begin
          state_s = ST_PLAY;
          time_s  = LEVEL_TIME_C;
          load_s  = 1'b1;
        end else if (startOfFrame) begin
          pause_cnt_s = pause_cnt_r - 8'd1;
        end else begin
          state_s = ST_PAUSE;
        end
      end
      ST_OVER, ST_WIN: begin
        if (key_edge_s) begin
          state_s = ST_WELCOME;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_WELCOME;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_WELCOME;
      pause_cnt_r <= 8'd0;
      bgState     <= BG_WELCOME;
      freezeGame  <= 1'b1;
      levelLoad   <= 1'b0;
      lives       <= 2'd0;
      level       <= 3'd0;
      timeLeft    <= 7'd0;
    end else begin
      state_r     <= state_s;
      pause_cnt_r <= pause_cnt_s;
      bgState     <= bg_of_state(state_s);
      freezeGame  <= (state_s != ST_PLAY);
      levelLoad   <= load_s;
      lives       <= lives_s;
      level       <= level_s;
      timeLeft    <= time_s;
    end
  end

  // Start-key edge register; preset so a key held through reset is not an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev_r <= 1'b1;
    end else begin
      key_prev_r <= startKey;
    end
  end

endmodule
